// File: rtl/shot_clock_ctrl.sv
// Shot clock sequencer: BCD countdown on synchronized timer toggles, with
// start/pause/reload control and a request/grant write-back to the display register.
module shot_clock_ctrl #(
  parameter int          LOAD_VAL      = 24,
  parameter int          TICKS_PER_DEC = 1,
  parameter logic [31:0] DISP_ADR      = 32'h0000FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_reload,
  input  logic        tick_toggle,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [6:0]  count,
  output logic        running,
  output logic        expired
);

  localparam int             PW        = (TICKS_PER_DEC > 1) ? $clog2(TICKS_PER_DEC) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_DEC - 1);
  localparam logic [6:0]     LOAD_CNT  = 7'(LOAD_VAL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WR} wb_state_t;

  state_t        state, state_n;
  wb_state_t     wb_state, wb_state_n;
  logic [6:0]    count_n;
  logic [PW-1:0] presc, presc_n;
  logic          dirty, dirty_n, set_dirty, grant;
  logic          tt_meta, tt_sync, tt_prev, tick_edge;
  logic          bus_req_n, bus_we_n;
  logic [31:0]   bus_adr_n, bus_wdata_n;
  logic [3:0]    tens, ones;

  // tick_toggle is asynchronous; every synchronized transition is one tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      tt_meta <= 1'b0;
      tt_sync <= 1'b0;
      tt_prev <= 1'b0;
    end else begin
      tt_meta <= tick_toggle;
      tt_sync <= tt_meta;
      tt_prev <= tt_sync;
    end
  end

  assign tick_edge = tt_sync ^ tt_prev;

  always_comb begin
    state_n   = state;
    count_n   = count;
    presc_n   = presc;
    set_dirty = 1'b0;
    if (btn_reload) begin
      state_n   = IDLE;
      count_n   = LOAD_CNT;
      presc_n   = '0;
      set_dirty = 1'b1;
    end else if (btn_pause) begin
      if (state == RUN) state_n = PAUSE;
    end else if (btn_start && (state == IDLE || state == PAUSE)) begin
      state_n = RUN;
    end else if (state == RUN && tick_edge) begin
      if (presc == PRESC_MAX) begin
        presc_n = '0;
        if (count != 7'd0) begin
          count_n   = count - 7'd1;
          set_dirty = 1'b1;
        end
        if (count <= 7'd1) state_n = EXPIRED;
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  // A change landing on the grant edge re-arms dirty for a second write
  assign grant   = (wb_state == WB_REQ) && bus_gnt;
  assign dirty_n = set_dirty | (dirty & ~grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= LOAD_CNT;
      presc   <= '0;
      dirty   <= 1'b1;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      presc   <= presc_n;
      dirty   <= dirty_n;
      running <= (state_n == RUN);
      expired <= (state_n == EXPIRED);
    end
  end

  assign tens = 4'(count / 7'd10);
  assign ones = 4'(count % 7'd10);

  always_comb begin
    wb_state_n  = wb_state;
    bus_req_n   = bus_req;
    bus_we_n    = 1'b0;
    bus_adr_n   = bus_adr;
    bus_wdata_n = bus_wdata;
    unique case (wb_state)
      WB_IDLE: begin
        if (dirty) begin
          bus_req_n  = 1'b1;
          wb_state_n = WB_REQ;
        end
      end
      WB_REQ: begin
        bus_req_n = 1'b1;
        if (bus_gnt) begin
          bus_adr_n   = DISP_ADR;
          bus_wdata_n = {24'd0, tens, ones};
          bus_we_n    = 1'b1;
          wb_state_n  = WB_WR;
        end
      end
      WB_WR: begin
        bus_req_n  = 1'b0;
        wb_state_n = WB_IDLE;
      end
      default: begin
        bus_req_n  = 1'b0;
        wb_state_n = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_state  <= WB_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_adr   <= '0;
      bus_wdata <= '0;
    end else begin
      wb_state  <= wb_state_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_adr   <= bus_adr_n;
      bus_wdata <= bus_wdata_n;
    end
  end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Bench for shot_clock_ctrl: table of control steps, hand-written bus/corner
// sequences and random control against an event-level model of the shot clock.
module tb_shot_clock_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_start = 1'b0, btn_pause = 1'b0, btn_reload = 1'b0;
  logic        tick_toggle = 1'b0;
  logic        bus_gnt = 1'b1;
  logic        bus_req, bus_we, running, expired;
  logic [31:0] bus_adr, bus_wdata;
  logic [6:0]  count;
  logic        bus_req4, bus_we4, running4, expired4;
  logic [31:0] bus_adr4, bus_wdata4;
  logic [6:0]  count4;

  int total = 0;
  int bad   = 0;

  int mcount[2];
  int mst[2];
  int macc[2];
  int tpd[2] = '{1, 4};
  bit mute_writes = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit watch_req = 1'b0;
  int req_low = 0;

  typedef struct {
    bit s;
    bit p;
    bit r;
    int ticks;
    int cnt;
    bit run;
    bit exp;
  } vec_t;
  vec_t vecs[14];

  shot_clock_ctrl dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_reload(btn_reload), .tick_toggle(tick_toggle), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .count(count), .running(running), .expired(expired)
  );

  shot_clock_ctrl #(.TICKS_PER_DEC(4)) dut4 (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_reload(btn_reload), .tick_toggle(tick_toggle), .bus_req(bus_req4),
    .bus_gnt(1'b1), .bus_adr(bus_adr4), .bus_wdata(bus_wdata4), .bus_we(bus_we4),
    .count(count4), .running(running4), .expired(expired4)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int c);
    return 32'(((c / 10) << 4) | (c % 10));
  endfunction

  // Bus monitor: collects every write strobe and checks the strobe framing
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (bus_we) begin
      got_q.push_back(bus_wdata);
      checkOutput("wr_adr", bus_adr, 32'h0000FF00);
      checkOutput("wr_req", {31'd0, bus_req}, 32'd1);
      checkOutput("we_single", {31'd0, prev_we}, 32'd0);
    end
    if (watch_req && !bus_req) req_low++;
    prev_we = bus_we;
  end

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mcount[i] = 24; mst[i] = M_IDLE; macc[i] = 0;
    end
    exp_q.push_back(bcd(24));
  endtask

  task automatic modelButton(input bit s, input bit p, input bit r);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mst[i] = M_IDLE; mcount[i] = 24; macc[i] = 0;
        if (i == 0) exp_q.push_back(bcd(24));
      end else if (p) begin
        if (mst[i] == M_RUN) mst[i] = M_PAUSE;
      end else if (s && (mst[i] == M_IDLE || mst[i] == M_PAUSE)) begin
        mst[i] = M_RUN;
      end
    end
  endtask

  task automatic modelTick();
    for (int i = 0; i < 2; i++) begin
      if (mst[i] == M_RUN) begin
        macc[i]++;
        if (macc[i] == tpd[i]) begin
          macc[i] = 0;
          if (mcount[i] > 0) begin
            mcount[i]--;
            if (i == 0 && !mute_writes) exp_q.push_back(bcd(mcount[i]));
          end
          if (mcount[i] == 0) mst[i] = M_EXP;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit r, input bit flip, input int settle);
    @(negedge clk);
    btn_start = s; btn_pause = p; btn_reload = r;
    if (flip) tick_toggle = ~tick_toggle;
    @(negedge clk);
    btn_start = 1'b0; btn_pause = 1'b0; btn_reload = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic press(input bit s, input bit p, input bit r);
    applyStimulus(s, p, r, 1'b0, 6);
    modelButton(s, p, r);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8);
    modelTick();
  endtask

  task automatic checkState(input string name);
    checkOutput({name, "_count"}, {25'd0, count}, 32'(mcount[0]));
    checkOutput({name, "_running"}, {31'd0, running}, {31'd0, mst[0] == M_RUN});
    checkOutput({name, "_expired"}, {31'd0, expired}, {31'd0, mst[0] == M_EXP});
    checkOutput({name, "_count4"}, {25'd0, count4}, 32'(mcount[1]));
  endtask

  task automatic checkWrites(input string name);
    int n;
    checkOutput({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_wr%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int waited;
    vecs[0]  = '{1, 0, 0, 0,  24, 1, 0};
    vecs[1]  = '{0, 0, 0, 3,  21, 1, 0};
    vecs[2]  = '{0, 1, 0, 2,  21, 0, 0};
    vecs[3]  = '{1, 0, 0, 14, 7,  1, 0};
    vecs[4]  = '{1, 1, 1, 0,  24, 0, 0};
    vecs[5]  = '{1, 0, 0, 24, 0,  0, 1};
    vecs[6]  = '{0, 0, 0, 1,  0,  0, 1};
    vecs[7]  = '{1, 0, 0, 0,  0,  0, 1};
    vecs[8]  = '{0, 1, 0, 0,  0,  0, 1};
    vecs[9]  = '{0, 0, 1, 0,  24, 0, 0};
    vecs[10] = '{0, 1, 0, 0,  24, 0, 0};
    vecs[11] = '{1, 0, 0, 9,  15, 1, 0};
    vecs[12] = '{0, 1, 0, 5,  15, 0, 0};
    vecs[13] = '{1, 0, 0, 1,  14, 1, 0};

    // Reset state, then the power-on write of LOAD_VAL
    repeat (3) @(negedge clk);
    checkOutput("rst_count", {25'd0, count}, 32'd24);
    checkOutput("rst_running", {31'd0, running}, 32'd0);
    checkOutput("rst_expired", {31'd0, expired}, 32'd0);
    checkOutput("rst_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_we", {31'd0, bus_we}, 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    reset = 1'b1;
    modelReset();
    repeat (10) @(negedge clk);
    checkWrites("boot");
    checkState("boot");

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].s || vecs[v].p || vecs[v].r) press(vecs[v].s, vecs[v].p, vecs[v].r);
      for (int k = 0; k < vecs[v].ticks; k++) tick();
      checkOutput($sformatf("vec%0d_count", v), {25'd0, count}, 32'(vecs[v].cnt));
      checkOutput($sformatf("vec%0d_running", v), {31'd0, running}, {31'd0, vecs[v].run});
      checkOutput($sformatf("vec%0d_expired", v), {31'd0, expired}, {31'd0, vecs[v].exp});
      checkOutput($sformatf("vec%0d_count4", v), {25'd0, count4}, 32'(mcount[1]));
      checkWrites($sformatf("vec%0d", v));
    end

    // Tick edge arriving together with a pause pulse must not decrement
    @(negedge clk); tick_toggle = ~tick_toggle;
    @(negedge clk);
    @(negedge clk); btn_pause = 1'b1;
    @(negedge clk); btn_pause = 1'b0;
    repeat (8) @(negedge clk);
    modelButton(1'b0, 1'b1, 1'b0);
    checkOutput("coinc_count", {25'd0, count}, 32'd14);
    checkState("coinc");
    checkWrites("coinc");

    // Grant withheld across three decrements: one coalesced write of 17
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    checkWrites("pre_gnt");
    @(negedge clk); bus_gnt = 1'b0;
    mute_writes = 1'b1;
    tick();
    waited = 0;
    while (!bus_req && waited < 20) begin @(negedge clk); waited++; end
    checkOutput("gnt_req_seen", {31'd0, bus_req}, 32'd1);
    watch_req = 1'b1;
    tick();
    tick();
    checkOutput("gnt_count", {25'd0, count}, 32'd17);
    checkWrites("gnt_wait");
    mute_writes = 1'b0;
    exp_q.push_back(bcd(17));
    @(negedge clk); bus_gnt = 1'b1;
    waited = 0;
    while (!bus_we && waited < 20) begin @(negedge clk); waited++; end
    checkOutput("gnt_we_seen", {31'd0, bus_we}, 32'd1);
    watch_req = 1'b0;
    @(negedge clk);
    checkOutput("gnt_req_drop", {31'd0, bus_req}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("gnt_req_held", 32'(req_low), 32'd0);
    checkWrites("gnt");
    checkState("gnt");

    // Reset asserted during the write strobe aborts it
    @(negedge clk); bus_gnt = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    waited = 0;
    while (!bus_req && waited < 20) begin @(negedge clk); waited++; end
    checkOutput("abort_req_seen", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    checkOutput("abort_we_high", {31'd0, bus_we}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_we_low", {31'd0, bus_we}, 32'd0);
    checkOutput("abort_req_low", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    repeat (10) @(negedge clk);
    checkWrites("abort");
    checkState("abort");

    // Four-tick prescaler keeps its partial count across a pause
    press(1'b1, 1'b0, 1'b0);
    tick(); tick();
    press(1'b0, 1'b1, 1'b0);
    tick(); tick();
    press(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("d4_hold", {25'd0, count4}, 32'd24);
    tick();
    checkOutput("d4_dec", {25'd0, count4}, 32'd23);
    checkState("d4");
    checkWrites("d4");

    // Random control traffic against the model
    for (int it = 0; it < 150; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 5) tick();
      else if (act == 6 || act == 9) press(1'b1, 1'b0, 1'b0);
      else if (act == 7) press(1'b0, 1'b1, 1'b0);
      else press(1'b0, 1'b0, 1'b1);
      checkState($sformatf("rnd%0d", it));
      if (it % 10 == 9) checkWrites($sformatf("rnd%0d", it));
    end
    checkWrites("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
